// File: rtl/m31_adder_arbiter.sv
// Round-robin arbiter that shares one two-stage M31 (p = 2^31-1) modular adder among NUM_REQ requesters.
// Each result is returned to the requester that issued it, with valid/ready backpressure on the result.
module m31_adder_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 31,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [1:0]                    in_flight
);

  localparam logic [ID_WIDTH-1:0]   LAST_ID = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [DATA_WIDTH-1:0] P_MOD   = {DATA_WIDTH{1'b1}};

  logic                  s1_v, s2_v;
  logic [DATA_WIDTH-1:0] s1_a, s1_b, s2_sum;
  logic [ID_WIDTH-1:0]   s1_owner, s2_owner, ptr;

  logic                  stall2, s1_free, accept, grant_found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [DATA_WIDTH:0]   raw_sum;
  logic [DATA_WIDTH-1:0] folded, sum;

  assign stall2  = s2_v & ~rsp_ready[s2_owner];
  assign s1_free = ~s1_v | ~stall2;
  assign accept  = grant_found & s1_free & rst_n;

  // Scan from ptr downward in priority: the lowest offset is written last and wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_WIDTH'((int'(ptr) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // End-around carry folds 2^31 back to 1; an all-ones result is the non-canonical zero.
  always_comb begin
    raw_sum = {1'b0, s1_a} + {1'b0, s1_b};
    folded  = raw_sum[DATA_WIDTH-1:0] + DATA_WIDTH'(raw_sum[DATA_WIDTH]);
    sum     = (folded == P_MOD) ? '0 : folded;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_owner <= '0;
      s2_v     <= 1'b0;
      s2_sum   <= '0;
      s2_owner <= '0;
      ptr      <= '0;
    end else begin
      if (!stall2) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_sum   <= sum;
          s2_owner <= s1_owner;
        end
      end
      if (s1_free) begin
        s1_v <= accept;
        if (accept) begin
          s1_a     <= req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          s1_b     <= req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          s1_owner <= grant_idx;
        end
      end
      if (accept) ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (s2_v) rsp_valid[s2_owner] = 1'b1;
  end

  assign rsp_data  = s2_sum;
  assign in_flight = {1'b0, s1_v} + {1'b0, s2_v};

endmodule

// File: tb/tb_m31_adder_arbiter.sv
// Directed bench for m31_adder_arbiter: results are predicted at request handshake and
// compared in order at response handshake against an independent modular-arithmetic model.
module tb_m31_adder_arbiter;

  localparam int N = 4;
  localparam int W = 31;

  typedef struct {
    logic [1:0]   owner;
    logic [W-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   rsp_data;
  logic [1:0]     in_flight;
  logic [W-1:0]   a_in [N];
  logic [W-1:0]   b_in [N];

  exp_t sb[$];
  int   grant_log[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  int   rsp_cnt  = 0;

  assign req_a = {a_in[3], a_in[2], a_in[1], a_in[0]};
  assign req_b = {b_in[3], b_in[2], b_in[1], b_in[0]};

  always #5 clk = ~clk;

  m31_adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .in_flight(in_flight)
  );

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] m31_ref(logic [W-1:0] a, logic [W-1:0] b);
    longint unsigned p = 64'd2147483647;
    return W'(((longint'(a) % p) + (longint'(b) % p)) % p);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes just after inputs settle, then advance one clock to the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    check("req_ready_onehot", 64'($onehot0(req_ready)), 64'd1);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.owner = 2'(i);
        e.data  = m31_ref(a_in[i], b_in[i]);
        sb.push_back(e);
        grant_log.push_back(i);
      end
    end
    if (|(rsp_valid & rsp_ready)) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", 64'(rsp_valid), 64'(4'b0001 << e.owner));
        check("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      a_in[i] = W'($urandom);
      b_in[i] = W'($urandom);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_single(int i, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] exp);
    req_valid    = '0;
    req_valid[i] = 1'b1;
    a_in[i]      = a;
    b_in[i]      = b;
    #1 check("single_grant", 64'(req_ready), 64'(4'b0001 << i));
    tick();
    req_valid = '0;
    #1 check("single_s1_only", 64'(in_flight), 64'd1);
    check("single_no_early_rsp", 64'(rsp_valid), 64'd0);
    tick();
    #1 check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << i));
    check("single_rsp_data", 64'(rsp_data), 64'(exp));
    tick();
    #1 check("single_drained", 64'(in_flight), 64'd0);
  endtask

  initial begin
    int base;
    int grant3;

    // Reset with requests pending: nothing may be granted while rst_n is low.
    rst_n     = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    randomize_operands();
    tick();
    tick();
    #1 check("rst_in_flight", 64'(in_flight), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // Single requests, including modular wrap and non-canonical zero inputs.
    run_single(0, 31'd5, 31'd7, 31'd12);
    run_single(1, 31'h7FFFFFFE, 31'h00000003, 31'd2);
    run_single(2, 31'h7FFFFFFE, 31'h00000001, 31'd0);
    run_single(3, 31'h7FFFFFFF, 31'h7FFFFFFF, 31'd0);

    // All requesters continuously valid: strict rotation and one result per cycle.
    grant_log.delete();
    base      = rsp_cnt;
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      randomize_operands();
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    check("rr_result_count", 64'(rsp_cnt - base), 64'd8);
    check("rr_grant_count", 64'(grant_log.size()), 64'd8);
    for (int g = 0; g < grant_log.size(); g++) check("rr_grant_order", 64'(grant_log[g]), 64'(g % N));
    drain();

    // Backpressure on requester 2 while 2 and 3 stream.
    req_valid = 4'b1100;
    rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      randomize_operands();
      tick();
      if (c >= 2) begin
        #1 check("bp_in_flight", 64'(in_flight), 64'd2);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'b0100);
        check("bp_rsp_data", 64'(rsp_data), 64'(sb[0].data));
      end
    end
    rsp_ready = '1;
    for (int c = 0; c < 4; c++) begin
      randomize_operands();
      tick();
    end
    req_valid = '0;
    drain();

    // Fairness: requester 1 always valid, requester 3 joins at cycle 3.
    grant3    = -1;
    req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) req_valid[3] = 1'b1;
      #1;
      if (req_valid[3] && req_ready[3] && grant3 < 0) grant3 = c;
      tick();
      if (grant3 >= 0) req_valid[3] = 1'b0;
    end
    check("fair_req3_granted_in_time", 64'(grant3 >= 3 && grant3 <= 4), 64'd1);
    req_valid = '0;
    drain();

    // Fill both stages under backpressure, then reset for one cycle.
    req_valid = 4'b0011;
    rsp_ready = '0;
    for (int c = 0; c < 10 && in_flight != 2'd2; c++) tick();
    #1 check("full_before_reset", 64'(in_flight), 64'd2);
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    rsp_ready = '1;
    req_valid = '1;
    sb.delete();
    #1 check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_in_flight", 64'(in_flight), 64'd0);
    check("post_rst_rsp_data", 64'(rsp_data), 64'd0);
    check("post_rst_ptr_zero", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    drain();
    for (int c = 0; c < 3; c++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
